// File: rtl/colisao_inimigo_pkg.sv
// rtl/colisao_inimigo_pkg.sv - shared game package: widths, defaults and damage FSM encoding
// Purpose: constants and types shared by the game blocks that track player damage.
// Contents: coordinate/lives widths, default lives, system clock rate, FSM state type.
package colisao_inimigo_pkg;

  localparam int COORD_W               = 10;
  localparam int VIDAS_W               = 3;
  localparam int VIDAS_INICIAIS_PADRAO = 3;
  // Used to express time windows in seconds at the board clock.
  localparam int CLK_HZ                = 50_000_000;

  typedef enum logic [1:0] {
    VIVO         = 2'd0,
    INVULNERAVEL = 2'd1,
    FIM          = 2'd2
  } estado_t;

endpackage

// File: rtl/colisao_inimigo_sobreposicao_caixas.sv
// rtl/colisao_inimigo_sobreposicao_caixas.sv - combinational axis-aligned box overlap test
// Purpose: reports whether two boxes given by top-left corner and size overlap.
// Ports: aX/aY/aLargura/aAltura (box A), bX/bY/bLargura/bAltura (box B),
//        sobrepoe (1 when the interiors intersect).
module sobreposicao_caixas
  import colisao_inimigo_pkg::*;
(
  input  logic [COORD_W-1:0] aX,
  input  logic [COORD_W-1:0] aY,
  input  logic [COORD_W-1:0] aLargura,
  input  logic [COORD_W-1:0] aAltura,
  input  logic [COORD_W-1:0] bX,
  input  logic [COORD_W-1:0] bY,
  input  logic [COORD_W-1:0] bLargura,
  input  logic [COORD_W-1:0] bAltura,
  output logic               sobrepoe
);

  // One extra bit so right/bottom edges never wrap.
  logic [COORD_W:0] a_dir, a_baixo, b_dir, b_baixo;
  logic             tem_area;

  assign a_dir   = {1'b0, aX} + {1'b0, aLargura};
  assign a_baixo = {1'b0, aY} + {1'b0, aAltura};
  assign b_dir   = {1'b0, bX} + {1'b0, bLargura};
  assign b_baixo = {1'b0, bY} + {1'b0, bAltura};

  // A zero-size box can still satisfy the strict inequalities when it sits
  // inside the other box, so it is excluded explicitly.
  assign tem_area = (aLargura != '0) && (aAltura != '0) &&
                    (bLargura != '0) && (bAltura != '0);

  assign sobrepoe = tem_area &&
                    ({1'b0, aX} < b_dir)   && ({1'b0, bX} < a_dir) &&
                    ({1'b0, aY} < b_baixo) && ({1'b0, bY} < a_baixo);

endmodule

// File: rtl/colisao_inimigo.sv
// rtl/colisao_inimigo.sv - enemy collision, lives and invulnerability tracker
// Purpose: turns player/enemy box overlap into hit pulses, a lives count, an
//          invulnerability window after each hit and a game-over flag.
// Ports: CLOCK_50, reset (sync, active-high), pausa (freeze), reiniciarJogo (restart),
//        jogador*/inimigo* boxes in; colidiu (hit pulse), vidas, invulneravel, fimDeJogo out.
module colisao_inimigo
  import colisao_inimigo_pkg::*;
#(
  parameter int VIDAS_INICIAIS = VIDAS_INICIAIS_PADRAO,
  parameter int T_INVULN       = CLK_HZ
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               pausa,
  input  logic               reiniciarJogo,
  input  logic [COORD_W-1:0] jogadorX,
  input  logic [COORD_W-1:0] jogadorY,
  input  logic [COORD_W-1:0] jogadorLargura,
  input  logic [COORD_W-1:0] jogadorAltura,
  input  logic [COORD_W-1:0] inimigoX,
  input  logic [COORD_W-1:0] inimigoY,
  input  logic [COORD_W-1:0] inimigoLargura,
  input  logic [COORD_W-1:0] inimigoAltura,
  output logic               colidiu,
  output logic [VIDAS_W-1:0] vidas,
  output logic               invulneravel,
  output logic               fimDeJogo
);

  // A window of one cycle still needs a 1-bit counter.
  localparam int              CNT_W = (T_INVULN > 1) ? $clog2(T_INVULN) : 1;
  localparam logic [CNT_W-1:0] CARGA = CNT_W'(T_INVULN - 1);

  estado_t          estado, estado_prox;
  logic [CNT_W-1:0] contador, contador_prox;
  logic [VIDAS_W-1:0] vidas_prox;
  logic             colidiu_prox;
  logic             sobrepoe, sob_r;

  sobreposicao_caixas u_sobreposicao (
    .aX       (jogadorX),
    .aY       (jogadorY),
    .aLargura (jogadorLargura),
    .aAltura  (jogadorAltura),
    .bX       (inimigoX),
    .bY       (inimigoY),
    .bLargura (inimigoLargura),
    .bAltura  (inimigoAltura),
    .sobrepoe (sobrepoe)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      estado   <= VIVO;
      contador <= '0;
      vidas    <= VIDAS_W'(VIDAS_INICIAIS);
      colidiu  <= 1'b0;
      sob_r    <= 1'b0;
    end else begin
      if (!pausa) sob_r <= sobrepoe;
      estado   <= estado_prox;
      contador <= contador_prox;
      vidas    <= vidas_prox;
      colidiu  <= colidiu_prox;
    end
  end

  // Pausa simply leaves every default (hold) in place and suppresses the pulse.
  always_comb begin
    estado_prox   = estado;
    contador_prox = contador;
    vidas_prox    = vidas;
    colidiu_prox  = 1'b0;
    if (!pausa) begin
      case (estado)
        VIVO: begin
          if (sob_r) begin
            colidiu_prox = 1'b1;
            vidas_prox   = vidas - VIDAS_W'(1);
            if (vidas == VIDAS_W'(1)) begin
              estado_prox = FIM;
            end else begin
              estado_prox   = INVULNERAVEL;
              contador_prox = CARGA;
            end
          end
        end
        INVULNERAVEL: begin
          if (contador == '0) estado_prox = VIVO;
          else                contador_prox = contador - CNT_W'(1);
        end
        FIM:     vidas_prox = '0;
        default: estado_prox = VIVO;
      endcase
    end
  end

  assign invulneravel = (estado == INVULNERAVEL);
  assign fimDeJogo    = (estado == FIM);

endmodule
